core_wb_stage: RTL and testbench
================================

Name: core_wb_stage

Overview:
- Writeback stage of the RV32IM pipeline, directly downstream of the memory stage.
- Consumes the registered W-side bundle: ALU result, destination register, write enable, load/store flag, load op, and raw memory read data with rvalid.
- Waits for load responses, aligns and sign/zero-extends load data, and drives the register-file write port one cycle later.
- Asserts a stall while a load response is outstanding.

Parameters:
- DATA_WIDTH, 32, datapath width (from the shared defines).
- REG_ADDR_WIDTH, 5, register address width.
- LOAD_OP_WIDTH, 3, load-op (funct3) width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- w_regfile_waddr_i  in  5  destination register.
- w_regfile_rd_i  in  32  ALU/result value for non-load writes.
- w_regfile_wr_i  in  1  instruction writes the register file.
- w_is_load_store_i  in  1  instruction is a memory access.
- w_is_load_i  in  1  instruction is a load (subset of load_store).
- w_LOAD_op_i  in  3  funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- w_addr_lsb_i  in  2  data address bits [1:0].
- w_data_rdata_i  in  32  raw memory read word.
- data_rvalid_i  in  1  read data valid.
- regfile_waddr_o  out  5  write address.
- regfile_wdata_o  out  32  write data.
- regfile_wr_o  out  1  write strobe.
- stall_wb_o  out  1  pipeline stall request (combinational).
- load_misaligned_o  out  1  one-cycle pulse on a misaligned load.
- spurious_rvalid_o  out  1  one-cycle pulse on rvalid with no load pending.

Behaviour:
- Reset: all outputs 0; FSM to IDLE; capture register 0.
- FSM states: IDLE, WAIT_RV.
- IDLE, non-load with wr_i=1:
  - Registered write next cycle: regfile_wr_o=1, waddr/wdata = inputs.
  - Latency 1.
  - Store (load_store=1, is_load=0): no write.
- IDLE, load, data_rvalid_i=1 in the same cycle:
  - Extend w_data_rdata_i.
  - Write next cycle.
  - Stay IDLE; stall_wb_o=0.
- IDLE, load, data_rvalid_i=0:
  - stall_wb_o=1 combinationally.
  - Go to WAIT_RV.
- WAIT_RV:
  - stall_wb_o = !data_rvalid_i.
  - Upstream holds all inputs stable while stalled.
  - On rvalid: capture and extend, write next cycle, return to IDLE.
- Extension:
  - byte = rdata[8*lsb +: 8].
  - half = rdata[16*lsb[1] +: 16].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
  - Any other op: treat as LW.
- Misalignment (LH/LHU with lsb[0]=1, or LW with lsb!=0):
  - No write.
  - load_misaligned_o pulses in the cycle the data is consumed.
  - No stall beyond the rvalid wait.
- x0: regfile_wr_o is forced 0 when waddr==0; waddr and wdata still update.
- rvalid in IDLE with no load present: ignored, spurious_rvalid_o=1 for one cycle.
- regfile_wr_o is a one-cycle pulse per retired instruction; never two writes for one held instruction.
- Reset during WAIT_RV: immediate return to IDLE, outputs cleared, no write.

Decomposition:
- Shared defines/package: LOAD_OP encodings (LB/LH/LW/LBU/LHU), DATA_WIDTH, REG_ADDR_WIDTH, LOAD_OP_WIDTH, FSM state encodings.
- One natural combinational sub-module: core_load_align (inputs rdata, op, lsb; outputs extended data and misaligned flag).

Test Plan:
- ADD result 0x0000_1234 to x5, wr=1 -> next cycle regfile_wr_o=1, waddr=5, wdata=0x0000_1234, stall never asserted.
- LB, lsb=2, rdata=0x0080_0000, rvalid in the same cycle -> write wdata=0xFFFF_FF80; LBU with the same inputs -> 0x0000_0080.
- LH, lsb=2, rvalid delayed 3 cycles, rdata=0x8001_xxxx:
  - stall_wb_o=1 for 3 cycles;
  - write 0xFFFF_8001 on the cycle after rvalid;
  - exactly one write.
- LW to x0, rdata=0xDEAD_BEEF -> regfile_wr_o stays 0.
- LW with lsb=1 -> load_misaligned_o pulse, no write.
- rvalid=1 in IDLE with no load -> spurious_rvalid_o pulse.
- rst_n low during WAIT_RV -> all outputs 0, state IDLE; a later rvalid produces no write.

Source files
------------

// File: rtl/core_wb_stage_pkg.sv
// rtl/core_wb_stage_pkg.sv - shared widths, load-op encodings and FSM states for the writeback stage
package core_wb_stage_pkg;

    localparam int WB_DATA_WIDTH     = 32;
    localparam int WB_REG_ADDR_WIDTH = 5;
    localparam int WB_LOAD_OP_WIDTH  = 3;

    typedef enum logic [2:0] {
        LOAD_LB  = 3'b000,
        LOAD_LH  = 3'b001,
        LOAD_LW  = 3'b010,
        LOAD_LBU = 3'b100,
        LOAD_LHU = 3'b101
    } load_op_e;

    typedef enum logic [0:0] {
        WB_IDLE    = 1'b0,
        WB_WAIT_RV = 1'b1
    } wb_state_e;

endpackage

// File: rtl/core_wb_stage_if.sv
// rtl/core_wb_stage_if.sv - registered W-side bundle from the memory stage plus the stall back to it
interface core_wb_stage_if #(
    parameter int DATA_WIDTH     = core_wb_stage_pkg::WB_DATA_WIDTH,
    parameter int REG_ADDR_WIDTH = core_wb_stage_pkg::WB_REG_ADDR_WIDTH,
    parameter int LOAD_OP_WIDTH  = core_wb_stage_pkg::WB_LOAD_OP_WIDTH
);
    logic [REG_ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0]     rd;
    logic                      wr;
    logic                      is_load_store;
    logic                      is_load;
    logic [LOAD_OP_WIDTH-1:0]  load_op;
    logic [1:0]                addr_lsb;
    logic [DATA_WIDTH-1:0]     rdata;
    logic                      rvalid;
    logic                      stall;

    modport master (
        output waddr, rd, wr, is_load_store, is_load, load_op, addr_lsb, rdata, rvalid,
        input  stall
    );

    modport slave (
        input  waddr, rd, wr, is_load_store, is_load, load_op, addr_lsb, rdata, rvalid,
        output stall
    );
endinterface

// File: rtl/core_load_align.sv
// rtl/core_load_align.sv - selects the addressed byte/half of a read word and extends it
module core_load_align
    import core_wb_stage_pkg::*;
#(
    parameter int DATA_WIDTH    = WB_DATA_WIDTH,
    parameter int LOAD_OP_WIDTH = WB_LOAD_OP_WIDTH
) (
    input  logic [DATA_WIDTH-1:0]    rdata,
    input  logic [LOAD_OP_WIDTH-1:0] op,
    input  logic [1:0]               lsb,
    output logic [DATA_WIDTH-1:0]    data,
    output logic                     misaligned
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Offsets are widened before scaling so the multiply cannot truncate.
    assign byte_sel = rdata[{lsb, 3'b000} +: 8];
    assign half_sel = rdata[{lsb[1], 4'b0000} +: 16];

    always_comb begin
        data       = rdata;
        misaligned = 1'b0;
        case (op)
            LOAD_LB:  data = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
            LOAD_LBU: data = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
            LOAD_LH: begin
                data       = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
                misaligned = lsb[0];
            end
            LOAD_LHU: begin
                data       = {{(DATA_WIDTH-16){1'b0}}, half_sel};
                misaligned = lsb[0];
            end
            default: begin
                data       = rdata;
                misaligned = (lsb != 2'b00);
            end
        endcase
    end
endmodule

// File: rtl/core_wb_stage.sv
// rtl/core_wb_stage.sv - RV32IM writeback: waits for load data, extends it, drives the regfile write port
module core_wb_stage
    import core_wb_stage_pkg::*;
#(
    parameter int DATA_WIDTH     = WB_DATA_WIDTH,
    parameter int REG_ADDR_WIDTH = WB_REG_ADDR_WIDTH,
    parameter int LOAD_OP_WIDTH  = WB_LOAD_OP_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    core_wb_stage_if.slave            w,
    output logic [REG_ADDR_WIDTH-1:0] regfile_waddr,
    output logic [DATA_WIDTH-1:0]     regfile_wdata,
    output logic                      regfile_wr,
    output logic                      load_misaligned,
    output logic                      spurious_rvalid
);
    wb_state_e             state_q, state_d;
    logic                  load_req;
    logic                  consume;
    logic                  alu_wr;
    logic                  stall_c;
    logic                  spurious_c;
    logic                  retire;
    logic [DATA_WIDTH-1:0] ld_data;
    logic                  ld_mis;

    core_load_align #(
        .DATA_WIDTH    (DATA_WIDTH),
        .LOAD_OP_WIDTH (LOAD_OP_WIDTH)
    ) u_align (
        .rdata      (w.rdata),
        .op         (w.load_op),
        .lsb        (w.addr_lsb),
        .data       (ld_data),
        .misaligned (ld_mis)
    );

    assign load_req = w.is_load_store & w.is_load;

    always_comb begin
        state_d    = state_q;
        consume    = 1'b0;
        alu_wr     = 1'b0;
        stall_c    = 1'b0;
        spurious_c = 1'b0;
        case (state_q)
            WB_IDLE: begin
                if (load_req) begin
                    if (w.rvalid) begin
                        consume = 1'b1;
                    end else begin
                        stall_c = 1'b1;
                        state_d = WB_WAIT_RV;
                    end
                end else begin
                    alu_wr     = w.wr & ~w.is_load_store;
                    spurious_c = w.rvalid;
                end
            end
            WB_WAIT_RV: begin
                if (w.rvalid) begin
                    consume = 1'b1;
                    state_d = WB_IDLE;
                end else begin
                    stall_c = 1'b1;
                end
            end
            default: state_d = WB_IDLE;
        endcase
    end

    // Combinational outputs are held low while reset is asserted.
    assign w.stall         = rst_n & stall_c;
    assign load_misaligned = rst_n & consume & ld_mis;
    assign spurious_rvalid = rst_n & spurious_c;

    assign retire = alu_wr | (consume & w.wr & ~ld_mis);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= WB_IDLE;
            regfile_wr    <= 1'b0;
            regfile_waddr <= '0;
            regfile_wdata <= '0;
        end else begin
            state_q <= state_d;
            if (retire) begin
                regfile_waddr <= w.waddr;
                regfile_wdata <= alu_wr ? w.rd : ld_data;
                // x0 still updates the visible address/data, only the strobe is suppressed.
                regfile_wr    <= |w.waddr;
            end else begin
                regfile_wr <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_core_wb_stage.sv
// tb/tb_core_wb_stage.sv - self-checking bench for core_wb_stage
module tb_core_wb_stage;
    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic [4:0]  regfile_waddr;
    logic [31:0] regfile_wdata;
    logic        regfile_wr;
    logic        load_misaligned;
    logic        spurious_rvalid;

    int checks   = 0;
    int errors   = 0;
    int wr_count = 0;

    always #5 clk = ~clk;

    core_wb_stage_if wif ();

    core_wb_stage dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .w               (wif.slave),
        .regfile_waddr   (regfile_waddr),
        .regfile_wdata   (regfile_wdata),
        .regfile_wr      (regfile_wr),
        .load_misaligned (load_misaligned),
        .spurious_rvalid (spurious_rvalid)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_ext(input logic [2:0] op, input logic [1:0] lsb,
                                              input logic [31:0] rdata);
        logic [31:0] b, h;
        b = (rdata >> (int'(lsb) * 8)) & 32'hFF;
        h = (rdata >> (int'(lsb[1]) * 16)) & 32'hFFFF;
        case (op)
            3'b000:  return (b >= 32'd128)   ? b + 32'hFFFF_FF00 : b;
            3'b001:  return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
            3'b100:  return b;
            3'b101:  return h;
            default: return rdata;
        endcase
    endfunction

    function automatic logic model_mis(input logic [2:0] op, input logic [1:0] lsb);
        case (op)
            3'b000, 3'b100: return 1'b0;
            3'b001, 3'b101: return lsb[0];
            default:        return lsb != 2'b00;
        endcase
    endfunction

    // Model: what the write port must show after each clock, from the retire rules.
    logic [4:0]  m_waddr = '0;
    logic [31:0] m_wdata = '0;
    logic        m_wr    = 1'b0;

    always @(posedge clk or negedge rst_n) begin : model
        logic lp;
        if (!rst_n) begin
            m_wr = 1'b0; m_waddr = '0; m_wdata = '0;
        end else begin
            lp = wif.is_load_store && wif.is_load;
            if (lp && wif.rvalid && wif.wr && !model_mis(wif.load_op, wif.addr_lsb)) begin
                m_waddr = wif.waddr;
                m_wdata = model_ext(wif.load_op, wif.addr_lsb, wif.rdata);
                m_wr    = (wif.waddr != 0);
            end else if (!wif.is_load_store && wif.wr) begin
                m_waddr = wif.waddr;
                m_wdata = wif.rd;
                m_wr    = (wif.waddr != 0);
            end else begin
                m_wr = 1'b0;
            end
        end
    end

    always @(negedge clk) begin : compare
        logic lp;
        lp = wif.is_load_store && wif.is_load;
        check("wr", 32'(regfile_wr), 32'(m_wr));
        check("waddr", 32'(regfile_waddr), 32'(m_waddr));
        check("wdata", regfile_wdata, m_wdata);
        check("stall", 32'(wif.stall), 32'(rst_n && lp && !wif.rvalid));
        check("misaligned", 32'(load_misaligned),
              32'(rst_n && lp && wif.rvalid && model_mis(wif.load_op, wif.addr_lsb)));
        check("spurious", 32'(spurious_rvalid), 32'(rst_n && wif.rvalid && !lp));
        if (regfile_wr) wr_count++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        wif.waddr = '0; wif.rd = '0; wif.wr = 1'b0; wif.is_load_store = 1'b0; wif.is_load = 1'b0;
        wif.load_op = '0; wif.addr_lsb = '0; wif.rdata = '0; wif.rvalid = 1'b0;
    endtask

    task automatic drive_alu(input logic [4:0] a, input logic [31:0] v, input logic ls);
        set_idle();
        wif.waddr = a; wif.rd = v; wif.wr = 1'b1; wif.is_load_store = ls;
    endtask

    task automatic drive_load(input logic [4:0] a, input logic [2:0] op, input logic [1:0] lsb,
                              input logic [31:0] rdata, input logic rv);
        set_idle();
        wif.waddr = a; wif.wr = 1'b1; wif.is_load_store = 1'b1; wif.is_load = 1'b1;
        wif.load_op = op; wif.addr_lsb = lsb; wif.rdata = rdata; wif.rvalid = rv;
    endtask

    initial begin
        int wc0;
        set_idle();
        #1 rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1;
        check("reset_wr", 32'(regfile_wr), 32'd0);
        check("reset_wdata", regfile_wdata, 32'd0);
        check("reset_waddr", 32'(regfile_waddr), 32'd0);

        drive_alu(5'd5, 32'h0000_1234, 1'b0);
        #1 check("add_stall", 32'(wif.stall), 32'd0);
        step();
        check("add_wr", 32'(regfile_wr), 32'd1);
        check("add_waddr", 32'(regfile_waddr), 32'd5);
        check("add_wdata", regfile_wdata, 32'h0000_1234);
        drive_alu(5'd6, 32'h5555_AAAA, 1'b1);
        step();
        check("store_no_wr", 32'(regfile_wr), 32'd0);

        drive_load(5'd7, 3'b000, 2'd2, 32'h0080_0000, 1'b1);
        step();
        check("lb_wdata", regfile_wdata, 32'hFFFF_FF80);
        drive_load(5'd8, 3'b100, 2'd2, 32'h0080_0000, 1'b1);
        step();
        check("lbu_wdata", regfile_wdata, 32'h0000_0080);
        drive_load(5'd9, 3'b000, 2'd3, 32'h7F00_0000, 1'b1);
        step();
        check("lb3_wdata", regfile_wdata, 32'h0000_007F);
        drive_load(5'd10, 3'b001, 2'd0, 32'h1234_FFFE, 1'b1);
        step();
        check("lh0_wdata", regfile_wdata, 32'hFFFF_FFFE);
        drive_load(5'd10, 3'b101, 2'd0, 32'h1234_FFFE, 1'b1);
        step();
        check("lhu0_wdata", regfile_wdata, 32'h0000_FFFE);
        drive_load(5'd12, 3'b011, 2'd0, 32'hCAFE_F00D, 1'b1);
        step();
        check("oddop_wdata", regfile_wdata, 32'hCAFE_F00D);
        set_idle();
        step();

        wc0 = wr_count;
        drive_load(5'd9, 3'b001, 2'd2, 32'h8001_1234, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1 check("lh_stall", 32'(wif.stall), 32'd1);
            step();
            check("lh_wait_wr", 32'(regfile_wr), 32'd0);
        end
        wif.rvalid = 1'b1;
        #1 check("lh_rv_stall", 32'(wif.stall), 32'd0);
        step();
        check("lh_wr", 32'(regfile_wr), 32'd1);
        check("lh_wdata", regfile_wdata, 32'hFFFF_8001);
        set_idle();
        step();
        check("lh_wr_after", 32'(regfile_wr), 32'd0);
        check("lh_one_write", 32'(wr_count - wc0), 32'd1);

        drive_load(5'd0, 3'b010, 2'd0, 32'hDEAD_BEEF, 1'b1);
        step();
        check("x0_wr", 32'(regfile_wr), 32'd0);
        check("x0_wdata", regfile_wdata, 32'hDEAD_BEEF);

        drive_load(5'd3, 3'b010, 2'd1, 32'h1111_2222, 1'b1);
        #1 check("mis_pulse", 32'(load_misaligned), 32'd1);
        step();
        check("mis_no_wr", 32'(regfile_wr), 32'd0);
        set_idle();
        #1 check("mis_clear", 32'(load_misaligned), 32'd0);
        step();

        wif.rvalid = 1'b1;
        #1 check("spur_pulse", 32'(spurious_rvalid), 32'd1);
        step();
        check("spur_no_wr", 32'(regfile_wr), 32'd0);
        wif.rvalid = 1'b0;
        #1 check("spur_clear", 32'(spurious_rvalid), 32'd0);
        step();

        drive_alu(5'd4, 32'h0BAD_F00D, 1'b0);
        step();
        drive_load(5'd11, 3'b010, 2'd0, 32'h2468_ACE0, 1'b0);
        step();
        check("rst_pre_stall", 32'(wif.stall), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_stall", 32'(wif.stall), 32'd0);
        check("rst_wr", 32'(regfile_wr), 32'd0);
        check("rst_waddr", 32'(regfile_waddr), 32'd0);
        check("rst_wdata", regfile_wdata, 32'd0);
        step();
        set_idle();
        rst_n = 1'b1;
        step();
        wif.rvalid = 1'b1;
        wif.rdata  = 32'h2468_ACE0;
        step();
        check("rst_late_rv_no_wr", 32'(regfile_wr), 32'd0);
        set_idle();
        step(); step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
